mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
- Sequencer directly upstream of the binary mux tree (mux2…mux512).
- Drives the tree's SEL input to step through a contiguous, wrapping range of input indices.
- Waits a programmable settle time for the combinational tree, then samples Z.
- Packs samples into OUT_W-bit words delivered over a valid/ready handshake; turns the N:1 tree into a readout engine for an I-bus snapshot.

Parameters:
SEL_W, 9, select width; tree width 2**SEL_W (9 = mux512)
SETTLE, 1, extra cycles SEL is held before Z is sampled (0 allowed)
OUT_W, 8, bits per output word (1..32)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  start-scan request, sampled while idle
FIRST  input  SEL_W  first index to scan, captured on accepted START
COUNT  input  SEL_W+1  number of samples, 0..2**SEL_W, captured on accepted START
SEL  output  SEL_W  select to mux tree
Z  input  1  mux tree output
BUSY  output  1  scan in progress
DOUT  output  OUT_W  packed sample word
DVALID  output  1  DOUT valid
DREADY  input  1  consumer ready
DONE  output  1  one-cycle pulse, scan complete

Behaviour:
- Reset is asynchronous and active-high; one clock (CLK). While RST is high:
  - SEL=0, BUSY=0, DOUT=0, DVALID=0, DONE=0.
  - Internal counters and pack register clear; state=IDLE.
  - Reset mid-scan abandons the scan, including any pending word.
- States:
  - IDLE: START=1 captures FIRST and COUNT and sets BUSY=1 next cycle.
    - COUNT=0: go to FIN.
    - Otherwise go to SCAN, with SEL=FIRST, settle counter=SETTLE, pack index=0.
  - SCAN: SEL is held for SETTLE+1 cycles. On the edge ending the last of those cycles:
    - Z is written to pack bit [pack index]; bit 0 is the first sample.
    - Remaining count decrements; SEL increments modulo 2**SEL_W (index 2**SEL_W-1 wraps to 0).
    - If pack index reaches OUT_W or remaining reaches 0, go to EMIT. Otherwise stay in SCAN with the settle counter reloaded.
  - EMIT:
    - DOUT = pack register with unfilled upper bits zero; DVALID=1.
    - SEL holds its already-incremented value; no sampling.
    - DOUT and DVALID stay stable until DVALID&&DREADY.
    - On handshake: DVALID=0 next cycle, pack clears. Go to SCAN if remaining>0 (full settle restarts), else FIN.
  - FIN: DONE=1 and BUSY=0 for exactly this cycle, then IDLE.
- START while BUSY=1 or in FIN is ignored. START in IDLE is accepted even if DREADY=0.
- FIRST, COUNT and Z are ignored outside their sampling points.
- Latency: first sample at edge SETTLE+1 after entering SCAN. A full word with DREADY=1 takes OUT_W*(SETTLE+1) cycles plus 1 EMIT cycle.
- COUNT=2**SEL_W scans every input once, ending with SEL back at FIRST.
- SEL changes only on SCAN sample edges and on START capture; it is glitch-free with respect to CLK.

Test Plan:
Bench Z model is combinational: Z = Ivec[SEL].
1. SEL_W=3, SETTLE=1, OUT_W=8, Ivec=0xA5, FIRST=0, COUNT=8, DREADY=1:
   - SEL walks 0..7, each held 2 cycles.
   - One word DOUT=0xA5, DVALID high 1 cycle.
   - DONE pulses once, BUSY low after.
2. Wrap and partial word, Ivec=0b01000011, FIRST=6, COUNT=4:
   - SEL sequence 6,7,0,1.
   - DOUT=0x0D (bits 1,0,1,1 from index 6,7,0,1), upper bits zero.
3. Backpressure, case 1 with DREADY=0 for 5 cycles after DVALID:
   - DOUT=0xA5, DVALID and SEL stay stable throughout.
   - Handshake on the first DREADY=1 cycle; DONE next cycle.
4. COUNT=0 with START:
   - BUSY=1 one cycle, then the DONE pulse.
   - DVALID never asserts; SEL unchanged.
5. Two words, COUNT=16, SEL_W=4, Ivec=0x3C5A:
   - Words 0x5A then 0x3C, in order.
   - A START pulsed between the two words is ignored.
6. RST asserted mid-scan, asynchronously between edges:
   - All outputs go to 0 immediately.
   - After release, a new START with FIRST=2, COUNT=1 yields a single sample of Ivec[2] with correct timing.

Source files
------------

// File: rtl/mux_scan_seq_if.sv
// Scan-sequencer bus: request/capture inputs, mux-tree select/sample pair and the packed-word handshake.
// master = sequencer side, slave = requester / mux tree / consumer side.
interface mux_scan_seq_if #(
   parameter int SEL_W = 9,
   parameter int OUT_W = 8
);
   logic             START;
   logic [SEL_W-1:0] FIRST;
   logic [SEL_W:0]   COUNT;
   logic [SEL_W-1:0] SEL;
   logic             Z;
   logic             BUSY;
   logic [OUT_W-1:0] DOUT;
   logic             DVALID;
   logic             DREADY;
   logic             DONE;

   modport master (
      input  START, FIRST, COUNT, Z, DREADY,
      output SEL, BUSY, DOUT, DVALID, DONE
   );

   modport slave (
      output START, FIRST, COUNT, Z, DREADY,
      input  SEL, BUSY, DOUT, DVALID, DONE
   );
endinterface

// File: rtl/mux_scan_seq.sv
// Steps a mux tree select over a wrapping index range, samples Z after SETTLE+1 cycles per index,
// and packs samples LSB-first into OUT_W-bit words held on DOUT/DVALID until DREADY.
module mux_scan_seq #(
   parameter int SEL_W  = 9,
   parameter int SETTLE = 1,
   parameter int OUT_W  = 8
) (
   input  logic          CLK,
   input  logic          RST,
   mux_scan_seq_if.master io
);
   localparam int PW = $clog2(OUT_W + 1);
   localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE);
   localparam logic [SW-1:0]    SETTLE_1  = SW'(1);
   localparam logic [PW-1:0]    IDX_1     = PW'(1);
   localparam logic [PW-1:0]    IDX_LAST  = PW'(OUT_W - 1);
   localparam logic [SEL_W:0]   REM_1     = (SEL_W + 1)'(1);
   localparam logic [SEL_W-1:0] SEL_1     = SEL_W'(1);

   logic [1:0]       state;
   logic [SEL_W-1:0] sel;
   logic [SW-1:0]    settle_cnt;
   logic [PW-1:0]    pack_idx;
   logic [SEL_W:0]   remaining;
   logic [OUT_W-1:0] pack;

   logic word_full;
   logic last_sample;

   assign word_full   = (pack_idx == IDX_LAST);
   assign last_sample = (remaining == REM_1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         sel        <= '0;
         settle_cnt <= '0;
         pack_idx   <= '0;
         remaining  <= '0;
         pack       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (io.START) begin
                  remaining  <= io.COUNT;
                  settle_cnt <= SETTLE_LD;
                  pack_idx   <= '0;
                  pack       <= '0;
                  // An empty scan leaves SEL untouched and spends one BUSY cycle before FIN.
                  if (io.COUNT != '0)
                     sel <= io.FIRST;
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (remaining == '0) begin
                  state <= S_FIN;
               end else if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - SETTLE_1;
               end else begin
                  pack       <= pack | (OUT_W'(io.Z) << pack_idx);
                  pack_idx   <= pack_idx + IDX_1;
                  remaining  <= remaining - REM_1;
                  sel        <= sel + SEL_1;
                  settle_cnt <= SETTLE_LD;
                  if (word_full || last_sample)
                     state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (io.DREADY) begin
                  pack       <= '0;
                  pack_idx   <= '0;
                  settle_cnt <= SETTLE_LD;
                  state      <= (remaining != '0) ? S_SCAN : S_FIN;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign io.SEL    = sel;
   assign io.BUSY   = (state == S_SCAN) || (state == S_EMIT);
   assign io.DVALID = (state == S_EMIT);
   assign io.DOUT   = (state == S_EMIT) ? pack : '0;
   assign io.DONE   = (state == S_FIN);
endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed and randomized scans of a 16-input tree, checked against a word/timing model built from the scan rules.
module tb_mux_scan_seq;
   localparam int SEL_W  = 4;
   localparam int SETTLE = 1;
   localparam int OUT_W  = 8;
   localparam int NIN    = 1 << SEL_W;

   logic clk;
   logic rst;
   logic [NIN-1:0] ivec;
   logic [SEL_W-1:0] cur_sel;
   int n_tests;
   int n_fail;

   mux_scan_seq_if #(.SEL_W(SEL_W), .OUT_W(OUT_W)) io ();

   mux_scan_seq #(.SEL_W(SEL_W), .SETTLE(SETTLE), .OUT_W(OUT_W)) dut (
      .CLK (clk),
      .RST (rst),
      .io  (io)
   );

   assign io.Z = ivec[io.SEL];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // mode: 0 = always ready, 1 = 5-cycle stall per word, 2 = random ready
   task automatic run_scan(input logic [SEL_W-1:0] f, input int c, input int mode, input bit noise);
      int exp_words[$];
      logic [SEL_W-1:0] seen[$];
      logic [SEL_W-1:0] e_sel;
      int nw, busy_cnt, done_cnt, stalls, widx, stall_run, cyc, exp_busy, exp_w, emit_end;
      bit fin, rdy;

      nw = (c + OUT_W - 1) / OUT_W;
      for (int w = 0; w < nw; w++) exp_words.push_back(0);
      for (int k = 0; k < c; k++)
         if (ivec[(int'(f) + k) % NIN]) exp_words[k / OUT_W] |= (1 << (k % OUT_W));

      busy_cnt = 0; done_cnt = 0; stalls = 0; widx = 0; stall_run = 0; cyc = 0; fin = 0;

      @(negedge clk);
      io.FIRST  = f;
      io.COUNT  = (SEL_W + 1)'(c);
      io.START  = 1'b1;
      io.DREADY = 1'($urandom_range(0, 1));
      @(negedge clk);
      io.START = 1'b0;
      io.FIRST = SEL_W'($urandom);
      io.COUNT = (SEL_W + 1)'($urandom);

      while (!fin && cyc < 400) begin
         cyc++;
         if (io.DONE) begin
            done_cnt++;
            fin = 1;
            check("busy_in_fin", io.BUSY, 0);
         end else if (io.BUSY) begin
            busy_cnt++;
            if (seen.size() == 0 || seen[$] !== io.SEL) seen.push_back(io.SEL);
         end else begin
            check("busy_dropped", io.BUSY, 1);
            fin = 1;
         end

         if (io.DVALID) begin
            exp_w = (widx < nw) ? exp_words[widx] : -1;
            check("dout", io.DOUT, exp_w);
            emit_end = ((widx + 1) * OUT_W < c) ? (widx + 1) * OUT_W : c;
            e_sel = SEL_W'((int'(f) + emit_end) % NIN);
            check("sel_emit", io.SEL, e_sel);
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (stall_run >= 5);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (rdy) begin
               widx++;
               stall_run = 0;
            end else begin
               stalls++;
               stall_run++;
            end
            io.DREADY = rdy;
         end else begin
            io.DREADY = 1'($urandom_range(0, 1));
         end

         if (noise && (io.BUSY || io.DONE)) begin
            io.START = 1'($urandom_range(0, 1));
            io.FIRST = SEL_W'($urandom);
            io.COUNT = (SEL_W + 1)'($urandom);
         end else begin
            io.START = 1'b0;
         end

         if (!fin) @(negedge clk);
      end
      if (!fin) check("scan_timeout", 0, 1);

      @(negedge clk);
      io.START = 1'b0;
      check("done_pulse_width", io.DONE, 0);
      check("busy_after_done", io.BUSY, 0);
      check("dvalid_after_done", io.DVALID, 0);

      exp_busy = (c == 0) ? 1 : c * (SETTLE + 1) + nw + stalls;
      check("done_count", done_cnt, 1);
      check("busy_cycles", busy_cnt, exp_busy);
      check("word_count", widx, nw);

      check("sel_trace_len", seen.size(), (c == 0) ? 1 : c + 1);
      for (int i = 0; i < seen.size() && i < ((c == 0) ? 1 : c + 1); i++) begin
         e_sel = (c == 0) ? cur_sel : SEL_W'((int'(f) + i) % NIN);
         check("sel_trace", seen[i], e_sel);
      end

      if (c != 0) cur_sel = SEL_W'((int'(f) + c) % NIN);
      check("sel_idle", io.SEL, cur_sel);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"}, io.SEL, 0);
      check({tag, "_busy"}, io.BUSY, 0);
      check({tag, "_dout"}, io.DOUT, 0);
      check({tag, "_dvalid"}, io.DVALID, 0);
      check({tag, "_done"}, io.DONE, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst       = 1'b0;
      io.START  = 1'b0;
      io.FIRST  = '0;
      io.COUNT  = '0;
      io.DREADY = 1'b0;
      ivec      = '0;
      cur_sel   = '0;

      #2 rst = 1'b1;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Full word, then a wrapping partial word, then the full word under backpressure.
      ivec = 16'h00A5;
      run_scan(4'd0, 8, 0, 0);
      ivec = 16'h4003;
      run_scan(4'd14, 4, 0, 0);
      ivec = 16'h00A5;
      run_scan(4'd0, 8, 1, 0);

      // Empty scan leaves SEL where the last scan left it.
      run_scan(4'd9, 0, 0, 0);

      // Two words in order with spurious STARTs while busy; every input once, SEL back at FIRST.
      ivec = 16'h3C5A;
      run_scan(4'd0, 16, 2, 1);
      ivec = 16'hBEEF;
      run_scan(4'd5, 16, 0, 0);

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      io.FIRST = 4'd3;
      io.COUNT = 5'd16;
      io.START = 1'b1;
      @(negedge clk);
      io.START = 1'b0;
      repeat (6) @(negedge clk);
      #3 rst = 1'b1;
      #1 check_all_zero("midscan_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cur_sel = '0;
      ivec = 16'($urandom);
      run_scan(4'd2, 1, 0, 0);

      for (int t = 0; t < 30; t++) begin
         ivec = 16'($urandom);
         run_scan(SEL_W'($urandom), $urandom_range(0, NIN), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
